// File: rtl/read_address_ctrl.sv
// Read-side pointer control for a synchronous FIFO.
// Tracks r_ptr against w_ptr and produces flags, level and a one-cycle read-valid.
module read_address_ctrl #(
    parameter int MEMORY_DEPTH = 4,
    parameter int ADDRESS_SIZE = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rd_req,
    input  logic                    flush,
    input  logic [ADDRESS_SIZE:0]   w_ptr,
    output logic [ADDRESS_SIZE:0]   r_ptr,
    output logic [ADDRESS_SIZE-1:0] r_addr,
    output logic                    mem_rd_en,
    output logic                    rd_valid,
    output logic                    empty,
    output logic                    full,
    output logic [ADDRESS_SIZE:0]   level,
    output logic                    cr_max,
    output logic                    underflow
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   rd_accept;
    logic   rd_reject;

    assign empty  = (r_ptr == w_ptr);
    assign full   = (r_ptr[ADDRESS_SIZE] != w_ptr[ADDRESS_SIZE]) &&
                    (r_ptr[ADDRESS_SIZE-1:0] == w_ptr[ADDRESS_SIZE-1:0]);
    assign level  = w_ptr - r_ptr;
    assign r_addr = r_ptr[ADDRESS_SIZE-1:0];
    assign cr_max = (r_addr == ADDRESS_SIZE'(MEMORY_DEPTH - 1));

    // Flush wins over a read request; full does not block reads.
    assign rd_accept = rd_req && !empty && !flush;
    assign rd_reject = rd_req && empty && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr     <= '0;
            underflow <= 1'b0;
        end else begin
            if (flush)
                r_ptr <= w_ptr;
            else if (rd_accept)
                r_ptr <= r_ptr + 1'b1;
            if (rd_reject)
                underflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: state_nxt = rd_accept ? BUSY : IDLE;
            BUSY: state_nxt = rd_accept ? BUSY : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_rd_en = rd_accept;
        rd_valid  = (state == BUSY);
    end

endmodule

// File: tb/tb_read_address_ctrl.sv
// Bench for read_address_ctrl: pointer model plus a read-address scoreboard
// that checks every rd_valid cycle against the address of the accepted read.
module tb_read_address_ctrl;

    logic       clk;
    logic       rst;
    logic       rd_req;
    logic       flush;
    logic [2:0] w_ptr;
    logic [2:0] r_ptr;
    logic [1:0] r_addr;
    logic       mem_rd_en;
    logic       rd_valid;
    logic       empty;
    logic       full;
    logic [2:0] level;
    logic       cr_max;
    logic       underflow;

    int checks = 0;
    int errors = 0;

    logic [1:0] exp_q[$];
    logic       mon_on = 1'b0;

    logic [2:0] m_rp   = '0;
    logic [2:0] m_rp_n = '0;
    logic       m_uf   = 1'b0;
    logic       m_uf_n = 1'b0;
    logic       acc;

    read_address_ctrl #(
        .MEMORY_DEPTH(4),
        .ADDRESS_SIZE(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_req   (rd_req),
        .flush    (flush),
        .w_ptr    (w_ptr),
        .r_ptr    (r_ptr),
        .r_addr   (r_addr),
        .mem_rd_en(mem_rd_en),
        .rd_valid (rd_valid),
        .empty    (empty),
        .full     (full),
        .level    (level),
        .cr_max   (cr_max),
        .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: each accepted read must show up as rd_valid one edge later.
    always begin : monitor
        logic       cap_en;
        logic [1:0] cap_addr;
        logic [1:0] e;
        @(posedge clk);
        cap_en   = mem_rd_en;
        cap_addr = r_addr;
        #1;
        if (mon_on) begin
            checks++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (rd_valid !== 1'b1 || cap_en !== 1'b1 || cap_addr !== e) begin
                    errors++;
                    $display("FAIL sb_read: rd_valid=%b rd_en=%b addr=%0d want 1 1 %0d",
                             rd_valid, cap_en, cap_addr, e);
                end
            end else if (rd_valid !== 1'b0) begin
                errors++;
                $display("FAIL sb_idle: rd_valid=%b want 0", rd_valid);
            end
        end
    end

    task automatic set_inputs(input logic rs, input logic rq,
                              input logic fl, input logic [2:0] wp);
        @(negedge clk);
        rst    = rs;
        rd_req = rq;
        flush  = fl;
        w_ptr  = wp;
        acc    = !rs && rq && !fl && (m_rp != wp);
        if (acc)
            exp_q.push_back(m_rp[1:0]);
        if (rs) begin
            m_rp_n = '0;
            m_uf_n = 1'b0;
        end else begin
            m_rp_n = fl ? wp : (acc ? m_rp + 3'd1 : m_rp);
            m_uf_n = m_uf || (rq && !fl && (m_rp == wp));
        end
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        m_rp = m_rp_n;
        m_uf = m_uf_n;
        #1;
    endtask

    task automatic test_reset();
        set_inputs(1'b1, 1'b1, 1'b0, 3'd0);
        tick();
        mon_on = 1'b1;
        set_inputs(1'b0, 1'b0, 1'b0, 3'd0);
        checks++;
        if (r_ptr !== 3'd0 || empty !== 1'b1 || full !== 1'b0 || level !== 3'd0) begin
            errors++;
            $display("FAIL reset_flags: r_ptr=%0d empty=%b full=%b level=%0d want 0 1 0 0",
                     r_ptr, empty, full, level);
        end
        checks++;
        if (rd_valid !== 1'b0 || underflow !== 1'b0 || mem_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: rd_valid=%b underflow=%b rd_en=%b want 0 0 0",
                     rd_valid, underflow, mem_rd_en);
        end
        tick();
    endtask

    task automatic test_full_read();
        set_inputs(1'b0, 1'b0, 1'b0, 3'd4);
        checks++;
        if (full !== 1'b1 || level !== 3'd4 || empty !== 1'b0) begin
            errors++;
            $display("FAIL full_flags: full=%b level=%0d empty=%b want 1 4 0",
                     full, level, empty);
        end
        tick();
        set_inputs(1'b0, 1'b1, 1'b0, 3'd4);
        checks++;
        if (mem_rd_en !== 1'b1 || r_addr !== 2'd0) begin
            errors++;
            $display("FAIL full_rd_en: rd_en=%b addr=%0d want 1 0", mem_rd_en, r_addr);
        end
        tick();
        checks++;
        if (r_ptr !== 3'd1 || rd_valid !== 1'b1 || full !== 1'b0 || level !== 3'd3) begin
            errors++;
            $display("FAIL full_after: r_ptr=%0d rd_valid=%b full=%b level=%0d want 1 1 0 3",
                     r_ptr, rd_valid, full, level);
        end
        set_inputs(1'b0, 1'b0, 1'b0, 3'd4);
        tick();
    endtask

    task automatic test_wrap();
        int cr_hits;
        bit wrapped;
        cr_hits = 0;
        wrapped = 1'b0;
        set_inputs(1'b1, 1'b0, 1'b0, 3'd0);
        tick();
        for (int i = 1; i <= 8; i++) begin
            set_inputs(1'b0, 1'b1, 1'b0, 3'(i));
            checks++;
            if (mem_rd_en !== 1'b1 || cr_max !== (m_rp[1:0] == 2'd3)) begin
                errors++;
                $display("FAIL wrap_comb: step=%0d rd_en=%b cr_max=%b want 1 %b",
                         i, mem_rd_en, cr_max, (m_rp[1:0] == 2'd3));
            end
            if (cr_max === 1'b1)
                cr_hits++;
            if (m_rp == 3'd7)
                wrapped = 1'b1;
            tick();
            checks++;
            if (r_ptr !== m_rp || underflow !== 1'b0) begin
                errors++;
                $display("FAIL wrap_ptr: step=%0d r_ptr=%0d uf=%b want %0d 0",
                         i, r_ptr, underflow, m_rp);
            end
        end
        checks++;
        if (!wrapped || r_ptr !== 3'd0 || cr_hits != 2) begin
            errors++;
            $display("FAIL wrap_end: r_ptr=%0d cr_hits=%0d want 0 2", r_ptr, cr_hits);
        end
        set_inputs(1'b0, 1'b0, 1'b0, 3'd0);
        tick();
    endtask

    task automatic test_underflow();
        set_inputs(1'b0, 1'b1, 1'b0, 3'd0);
        checks++;
        if (mem_rd_en !== 1'b0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL uf_comb: rd_en=%b empty=%b want 0 1", mem_rd_en, empty);
        end
        tick();
        checks++;
        if (r_ptr !== 3'd0 || underflow !== 1'b1) begin
            errors++;
            $display("FAIL uf_set: r_ptr=%0d uf=%b want 0 1", r_ptr, underflow);
        end
        for (int i = 0; i < 2; i++) begin
            set_inputs(1'b0, 1'b1, 1'b0, 3'd2);
            tick();
            checks++;
            if (underflow !== 1'b1 || r_ptr !== m_rp) begin
                errors++;
                $display("FAIL uf_hold: uf=%b r_ptr=%0d want 1 %0d", underflow, r_ptr, m_rp);
            end
        end
    endtask

    task automatic test_flush();
        set_inputs(1'b0, 1'b0, 1'b0, 3'd6);
        tick();
        set_inputs(1'b0, 1'b1, 1'b1, 3'd6);
        checks++;
        if (mem_rd_en !== 1'b0 || r_ptr !== 3'd2) begin
            errors++;
            $display("FAIL flush_comb: rd_en=%b r_ptr=%0d want 0 2", mem_rd_en, r_ptr);
        end
        tick();
        checks++;
        if (r_ptr !== 3'd6 || empty !== 1'b1 || rd_valid !== 1'b0 || underflow !== 1'b1) begin
            errors++;
            $display("FAIL flush_after: r_ptr=%0d empty=%b rd_valid=%b uf=%b want 6 1 0 1",
                     r_ptr, empty, rd_valid, underflow);
        end
    endtask

    task automatic test_reset_abort();
        set_inputs(1'b0, 1'b0, 1'b0, 3'd7);
        tick();
        set_inputs(1'b1, 1'b1, 1'b0, 3'd7);
        tick();
        checks++;
        if (r_ptr !== 3'd0 || rd_valid !== 1'b0 || underflow !== 1'b0 || level !== 3'd7) begin
            errors++;
            $display("FAIL rst_abort: r_ptr=%0d rd_valid=%b uf=%b level=%0d want 0 0 0 7",
                     r_ptr, rd_valid, underflow, level);
        end
    endtask

    task automatic test_back_to_back();
        int budget;
        set_inputs(1'b0, 1'b1, 1'b0, 3'd4);
        checks++;
        if (full !== 1'b1 || mem_rd_en !== 1'b1) begin
            errors++;
            $display("FAIL b2b_full_rd: full=%b rd_en=%b want 1 1", full, mem_rd_en);
        end
        tick();
        set_inputs(1'b0, 1'b1, 1'b0, 3'd5);
        checks++;
        if (level !== 3'd4 || full !== 1'b1) begin
            errors++;
            $display("FAIL b2b_level: level=%0d full=%b want 4 1", level, full);
        end
        tick();
        checks++;
        if (r_ptr !== 3'd2 || level !== 3'd3 || rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_after: r_ptr=%0d level=%0d rd_valid=%b want 2 3 1",
                     r_ptr, level, rd_valid);
        end
        budget = 20;
        while (m_rp != 3'd5 && budget > 0) begin
            set_inputs(1'b0, 1'b1, 1'b0, 3'd5);
            tick();
            budget--;
        end
        set_inputs(1'b0, 1'b0, 1'b0, 3'd5);
        tick();
        checks++;
        if (empty !== 1'b1 || r_ptr !== 3'd5 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: empty=%b r_ptr=%0d uf=%b want 1 5 0",
                     empty, r_ptr, underflow);
        end
    endtask

    initial begin
        rst    = 1'b1;
        rd_req = 1'b0;
        flush  = 1'b0;
        w_ptr  = '0;
        test_reset();
        test_full_read();
        test_wrap();
        test_underflow();
        test_flush();
        test_reset_abort();
        test_back_to_back();
        set_inputs(1'b0, 1'b0, 1'b0, 3'd5);
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: pending=%0d want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
